fft_output_streamer: RTL and testbench
======================================

FFT_OUTPUT_STREAMER -- requirements
Module: fft_output_streamer

Interface
REQ-001 SHALL have parameter N, default 32: FFT length, power of 2, >= 4.
REQ-002 SHALL have parameter word_size, default 16: bits per sample.
REQ-003 SHALL have parameter LANES, default 2: samples per beat, power of 2, divides N, 1..N/2.
REQ-004 SHALL have parameter RD_LATENCY, default 1: memory read latency in cycles, 1..4.
REQ-005 SHALL have derived parameter address_width = $clog2(N).
REQ-006 clk  in  1  single clock; all state on rising edge.
REQ-007 reset  in  1  asynchronous, active-high; clears all state immediately.
REQ-008 start  in  1  frame request; accepted only in IDLE.
REQ-009 bit_rev  in  1  read order; sampled with accepted start; 1 = bit-reversed addressing.
REQ-010 rd_en  out  1  memory read strobe, one beat per cycle.
REQ-011 rd_addr  out  LANES*address_width  lane l at bits [l*address_width +: address_width].
REQ-012 rd_data  in  LANES*word_size  memory data, valid RD_LATENCY cycles after its rd_en cycle.
REQ-013 out_data  out  LANES*word_size  output beat, lane order matching rd_addr.
REQ-014 out_valid / out_ready  out / in  1 each  stream handshake; transfer when both high.
REQ-015 out_last  out  1  high with the final beat of the frame.
REQ-016 busy  out  1  high from the cycle after start acceptance through the last-beat transfer cycle.
REQ-017 done  out  1  one-cycle pulse in the cycle after the last-beat transfer.

Function
REQ-018 SHALL implement an FSM with states IDLE -> RUN on accepted start; RUN -> DRAIN after the rd_en for beat N/LANES-1; DRAIN -> IDLE on last-beat transfer.
REQ-019 start in RUN or DRAIN SHALL be ignored; start in the done-pulse cycle SHALL be accepted (state is IDLE).
REQ-020 For beat b and lane l, natural index k = b*LANES + l; rd_addr lane l SHALL be k if latched bit_rev = 0, else k with its address_width bits reversed.
REQ-021 Beats SHALL be issued b = 0 .. N/LANES-1 in order with no skips or repeats; the beat counter SHALL reset to 0 on each accepted start.
REQ-022 An internal output FIFO of depth D = RD_LATENCY+2 SHALL capture rd_data; reads in flight SHALL be tracked by a pipeline of valid bits RD_LATENCY deep.
REQ-023 rd_en SHALL assert in RUN only when (FIFO occupancy + reads in flight) < D; the FIFO SHALL never overflow.
REQ-024 With out_ready held at 1, rd_en SHALL assert every cycle of RUN, giving one beat per cycle.
REQ-025 Latency: start accepted in cycle t -> first rd_en in t+1 -> first out_valid in t+2+RD_LATENCY.
REQ-026 While out_valid = 1 and out_ready = 0, out_data and out_last SHALL hold stable.
REQ-027 out_valid SHALL be 1 exactly when the FIFO is non-empty; out_last SHALL be 1 only on beat N/LANES-1.
REQ-028 In a cycle where the FIFO writes and pops simultaneously, occupancy SHALL be unchanged and both operations SHALL complete.
REQ-029 FIFO and beat pointers SHALL wrap modulo their depth; no arithmetic overflow is permitted.

Reset
REQ-030 While reset is high, the block SHALL hold: state IDLE; rd_en, out_valid, out_last, busy and done = 0; rd_addr and out_data = 0; FIFO empty; in-flight pipeline cleared; beat counter 0.
REQ-031 Reset asserted mid-frame SHALL abandon the frame with no further out_valid; the next accepted start SHALL begin at beat 0.

Verification
REQ-032 Natural order, N=8, LANES=2, RD_LATENCY=1, out_ready=1, memory data = address -> rd_addr pairs (0,1),(2,3),(4,5),(6,7) on consecutive cycles; out_data pairs match; out_last on the 4th beat; done one cycle later.
REQ-033 Same setup with bit_rev=1 at start -> rd_addr pairs (0,4),(2,6),(1,5),(3,7); out_data carries the same values.
REQ-034 out_ready=0 for 3 cycles after the 2nd beat -> out_data held; rd_en stalls once occupancy plus in-flight = 3; all 4 beats delivered once each, in order.
REQ-035 Async reset pulse during RUN -> outputs zero without waiting for a clock edge; a new start -> rd_addr begins at (0,1).
REQ-036 start asserted during RUN -> ignored, with exactly 4 beats delivered; start held high through the done cycle -> second frame begins at the next cycle.
REQ-037 LANES=1, RD_LATENCY=3, N=8 -> first out_valid at t+5; 8 beats with data 0..7; out_last on the 8th beat.

Source files
------------

// File: rtl/fft_output_streamer.sv
// Purpose: reads an N-point FFT result from memory in natural or bit-reversed order and streams it LANES samples per beat.
// Latency: start accepted in cycle t -> first rd_en in t+1 -> first out_valid in t+2+RD_LATENCY; one beat per cycle with out_ready high.
// Backpressure: out_ready low holds the current beat; reads pause while buffered plus in-flight beats fill the RD_LATENCY+2 entry FIFO.
//
// Ports:
//   clk, reset            single clock, asynchronous active-high reset
//   start, bit_rev        frame request (taken only when idle) and read order captured with it
//   rd_en, rd_addr        one memory read per cycle, LANES addresses packed lane 0 in the LSBs
//   rd_data               memory data, valid RD_LATENCY cycles after its rd_en cycle
//   out_data/valid/ready  output stream, lanes in rd_addr order; out_last marks the final beat
//   busy, done            busy from the cycle after start through the last transfer; done pulses after it
module fft_output_streamer #(
  parameter int N             = 32,
  parameter int word_size     = 16,
  parameter int LANES         = 2,
  parameter int RD_LATENCY    = 1,
  parameter int address_width = $clog2(N)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic                           bit_rev,
  output logic                           rd_en,
  output logic [LANES*address_width-1:0] rd_addr,
  input  logic [LANES*word_size-1:0]     rd_data,
  output logic [LANES*word_size-1:0]     out_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic                           out_last,
  output logic                           busy,
  output logic                           done
);

  localparam int BEATS  = N / LANES;
  localparam int BEAT_W = $clog2(BEATS);
  localparam int D      = RD_LATENCY + 2;
  localparam int PTR_W  = $clog2(D);
  localparam int CNT_W  = $clog2(D + 1);
  localparam int DW     = LANES * word_size;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  typedef struct packed {
    logic          last;
    logic [DW-1:0] dat;
  } entry_t;

  state_t                   state_q, state_d;
  logic [BEAT_W-1:0]        beat_q, beat_d;
  logic                     bit_rev_q, bit_rev_d;
  logic                     done_q, done_d;
  logic [RD_LATENCY-1:0]    pipe_vld_q, pipe_vld_d;
  logic [RD_LATENCY-1:0]    pipe_last_q, pipe_last_d;
  entry_t                   mem_q [D];
  entry_t                   mem_d [D];
  logic [PTR_W-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]         count_q, count_d;

  logic [3:0]               inflight;
  logic                     last_issue;
  logic                     push;
  logic                     pop;
  entry_t                   head;
  logic [address_width-1:0] k_nat;
  logic [address_width-1:0] k_rev;

  // D is generally not a power of two, so pointers wrap explicitly.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(D - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LATENCY; i++) begin
      inflight = inflight + 4'(pipe_vld_q[i]);
    end
  end

  // Every read issued already owns a FIFO slot: buffered + in flight never exceeds D.
  assign rd_en      = (state_q == RUN) && ((4'(count_q) + inflight) < 4'(D));
  assign last_issue = rd_en && (beat_q == BEAT_W'(BEATS - 1));
  assign push       = pipe_vld_q[RD_LATENCY-1];
  assign head       = mem_q[rd_ptr_q];
  assign out_valid  = (count_q != '0);
  assign out_data   = out_valid ? head.dat : '0;
  assign out_last   = out_valid && head.last;
  assign pop        = out_valid && out_ready;
  assign busy       = (state_q != IDLE);
  assign done       = done_q;

  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    bit_rev_d = bit_rev_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = RUN;
          beat_d    = '0;
          bit_rev_d = bit_rev;
        end
      end
      RUN: begin
        if (rd_en) begin
          beat_d = beat_q + BEAT_W'(1);
          if (last_issue) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (pop && out_last) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Read-tracking pipeline and output FIFO; the last flag travels with each read.
  always_comb begin
    pipe_vld_d     = '0;
    pipe_last_d    = '0;
    pipe_vld_d[0]  = rd_en;
    pipe_last_d[0] = last_issue;
    for (int i = 1; i < RD_LATENCY; i++) begin
      pipe_vld_d[i]  = pipe_vld_q[i-1];
      pipe_last_d[i] = pipe_last_q[i-1];
    end
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q].last = pipe_last_q[RD_LATENCY-1];
      mem_d[wr_ptr_q].dat  = rd_data;
      wr_ptr_d             = ptr_inc(wr_ptr_q);
    end
    if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);
    if (push && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (pop && !push) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  // Lane l of beat b reads natural index b*LANES+l, optionally bit-reversed.
  always_comb begin
    rd_addr = '0;
    k_nat   = '0;
    k_rev   = '0;
    for (int l = 0; l < LANES; l++) begin
      k_nat = address_width'(int'(beat_q) * LANES + l);
      for (int i = 0; i < address_width; i++) begin
        k_rev[i] = k_nat[address_width-1-i];
      end
      if (rd_en) rd_addr[l*address_width +: address_width] = bit_rev_q ? k_rev : k_nat;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      beat_q      <= '0;
      bit_rev_q   <= 1'b0;
      done_q      <= 1'b0;
      pipe_vld_q  <= '0;
      pipe_last_q <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      for (int i = 0; i < D; i++) mem_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      bit_rev_q   <= bit_rev_d;
      done_q      <= done_d;
      pipe_vld_q  <= pipe_vld_d;
      pipe_last_q <= pipe_last_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      mem_q       <= mem_d;
    end
  end

endmodule

// File: tb/tb_fft_output_streamer.sv
module tb_fft_output_streamer;

  logic        clk, reset;
  logic        start, bit_rev, out_ready;
  logic        rd_en, out_valid, out_last, busy, done;
  logic [5:0]  rd_addr;
  logic [31:0] rd_data, out_data, rdp_a;

  logic        start_b, bit_rev_b, out_ready_b;
  logic        rd_en_b, out_valid_b, out_last_b, busy_b, done_b;
  logic [2:0]  rd_addr_b;
  logic [15:0] rd_data_b, out_data_b;
  logic [15:0] rdp_b [3];

  int n_tests, n_fail, cyc, t0;

  logic [5:0]  iss_addr [$];
  int          iss_cyc [$];
  logic [31:0] xf_data [$];
  logic        xf_last [$];
  int          xf_cyc [$];
  int          done_cyc [$];
  logic [2:0]  b_iss [$];
  int          b_iss_cyc [$];
  logic [15:0] b_xf [$];
  logic        b_last [$];
  int          b_xf_cyc [$];
  int          b_done_cyc [$];

  // Hand-computed expectations for N=8, LANES=2 (lane 0 in the low bits).
  logic [5:0]  nat_addr [4] = '{6'h08, 6'h1A, 6'h2C, 6'h3E};
  logic [31:0] nat_data [4] = '{32'h0001_0000, 32'h0003_0002, 32'h0005_0004, 32'h0007_0006};
  logic [5:0]  rev_addr [4] = '{6'h20, 6'h32, 6'h29, 6'h3B};
  logic [31:0] rev_data [4] = '{32'h0004_0000, 32'h0006_0002, 32'h0005_0001, 32'h0007_0003};
  int exp_iss [4];
  int exp_xf [4];
  int exp_done;

  fft_output_streamer #(.N(8), .word_size(16), .LANES(2), .RD_LATENCY(1)) dut (
    .clk(clk), .reset(reset), .start(start), .bit_rev(bit_rev), .rd_en(rd_en),
    .rd_addr(rd_addr), .rd_data(rd_data), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last), .busy(busy), .done(done));

  fft_output_streamer #(.N(8), .word_size(16), .LANES(1), .RD_LATENCY(3)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .bit_rev(bit_rev_b), .rd_en(rd_en_b),
    .rd_addr(rd_addr_b), .rd_data(rd_data_b), .out_data(out_data_b), .out_valid(out_valid_b),
    .out_ready(out_ready_b), .out_last(out_last_b), .busy(busy_b), .done(done_b));

  always #5 clk = ~clk;

  // Memories whose content equals the address, with the configured read latency.
  always @(posedge clk) begin
    rdp_a    <= {13'd0, rd_addr[5:3], 13'd0, rd_addr[2:0]};
    rdp_b[0] <= {13'd0, rd_addr_b};
    rdp_b[1] <= rdp_b[0];
    rdp_b[2] <= rdp_b[1];
  end
  assign rd_data   = rdp_a;
  assign rd_data_b = rdp_b[2];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle's inputs, log that cycle's events, advance to the next mid-cycle point.
  task automatic tick(input logic s, input logic br, input logic rdy, input logic sb);
    start = s; bit_rev = br; out_ready = rdy; start_b = sb;
    if (rd_en) begin iss_addr.push_back(rd_addr); iss_cyc.push_back(cyc); end
    if (out_valid && out_ready) begin
      xf_data.push_back(out_data); xf_last.push_back(out_last); xf_cyc.push_back(cyc);
    end
    if (done) done_cyc.push_back(cyc);
    if (rd_en_b) begin b_iss.push_back(rd_addr_b); b_iss_cyc.push_back(cyc); end
    if (out_valid_b && out_ready_b) begin
      b_xf.push_back(out_data_b); b_last.push_back(out_last_b); b_xf_cyc.push_back(cyc);
    end
    if (done_b) b_done_cyc.push_back(cyc);
    @(negedge clk);
    cyc++;
  endtask

  task automatic clear_logs();
    iss_addr.delete(); iss_cyc.delete(); xf_data.delete(); xf_last.delete();
    xf_cyc.delete(); done_cyc.delete(); b_iss.delete(); b_iss_cyc.delete();
    b_xf.delete(); b_last.delete(); b_xf_cyc.delete(); b_done_cyc.delete();
  endtask

  task automatic check_frame(input string tag, input int t, input bit rev);
    chk({tag, ".n_issue"}, 64'(iss_addr.size()), 64'd4);
    chk({tag, ".n_xfer"}, 64'(xf_data.size()), 64'd4);
    chk({tag, ".n_done"}, 64'(done_cyc.size()), 64'd1);
    for (int i = 0; i < 4; i++) begin
      if (i < iss_addr.size()) begin
        chk($sformatf("%s.addr%0d", tag, i), 64'(iss_addr[i]), 64'(rev ? rev_addr[i] : nat_addr[i]));
        chk($sformatf("%s.issue_cyc%0d", tag, i), 64'(iss_cyc[i]), 64'(t + exp_iss[i]));
      end
      if (i < xf_data.size()) begin
        chk($sformatf("%s.data%0d", tag, i), 64'(xf_data[i]), 64'(rev ? rev_data[i] : nat_data[i]));
        chk($sformatf("%s.xfer_cyc%0d", tag, i), 64'(xf_cyc[i]), 64'(t + exp_xf[i]));
        chk($sformatf("%s.last%0d", tag, i), 64'(xf_last[i]), 64'(i == 3));
      end
    end
    if (done_cyc.size() > 0) chk({tag, ".done_cyc"}, 64'(done_cyc[0]), 64'(t + exp_done));
  endtask

  initial begin
    clk = 0; reset = 1; start = 0; bit_rev = 0; out_ready = 1;
    start_b = 0; bit_rev_b = 0; out_ready_b = 1;
    n_tests = 0; n_fail = 0; cyc = 0;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst.rd_en", 64'(rd_en), 64'd0);
    chk("rst.rd_addr", 64'(rd_addr), 64'd0);
    chk("rst.out_valid", 64'(out_valid), 64'd0);
    chk("rst.out_data", 64'(out_data), 64'd0);
    chk("rst.out_last", 64'(out_last), 64'd0);
    chk("rst.busy", 64'(busy), 64'd0);
    chk("rst.done", 64'(done), 64'd0);
    chk("rst.b_rd_addr", 64'(rd_addr_b), 64'd0);
    chk("rst.b_out_valid", 64'(out_valid_b), 64'd0);
    reset = 0;
    repeat (2) tick(0, 0, 1, 0);

    // Natural order, out_ready high
    exp_iss = '{1, 2, 3, 4}; exp_xf = '{3, 4, 5, 6}; exp_done = 7;
    clear_logs(); t0 = cyc;
    tick(1, 0, 1, 0);
    chk("nat.busy_t1", 64'(busy), 64'd1);
    chk("nat.rd_addr_t1", 64'(rd_addr), 64'h08);
    repeat (10) tick(0, 0, 1, 0);
    check_frame("nat", t0, 1'b0);
    chk("nat.busy_after", 64'(busy), 64'd0);

    // Bit-reversed order; bit_rev high only in the start cycle
    clear_logs(); t0 = cyc;
    tick(1, 1, 1, 0);
    repeat (10) tick(0, 0, 1, 0);
    check_frame("rev", t0, 1'b1);

    // Backpressure: out_ready low for three cycles after the 2nd read
    exp_iss = '{1, 2, 3, 7}; exp_xf = '{6, 7, 8, 9}; exp_done = 10;
    clear_logs(); t0 = cyc;
    tick(1, 0, 1, 0);
    repeat (2) tick(0, 0, 1, 0);
    tick(0, 0, 0, 0);
    chk("stall.valid_t4", 64'(out_valid), 64'd1);
    chk("stall.data_t4", 64'(out_data), 64'h0001_0000);
    chk("stall.rd_en_t4", 64'(rd_en), 64'd0);
    tick(0, 0, 0, 0);
    chk("stall.data_t5", 64'(out_data), 64'h0001_0000);
    chk("stall.last_t5", 64'(out_last), 64'd0);
    tick(0, 0, 0, 0);
    chk("stall.data_t6", 64'(out_data), 64'h0001_0000);
    chk("stall.rd_en_t6", 64'(rd_en), 64'd0);
    repeat (8) tick(0, 0, 1, 0);
    check_frame("stall", t0, 1'b0);

    // Asynchronous reset mid-frame, then a fresh frame
    clear_logs();
    tick(1, 0, 1, 0);
    repeat (2) tick(0, 0, 1, 0);
    chk("arst.valid_before", 64'(out_valid), 64'd1);
    reset = 1;
    #1;
    chk("arst.rd_en", 64'(rd_en), 64'd0);
    chk("arst.rd_addr", 64'(rd_addr), 64'd0);
    chk("arst.out_valid", 64'(out_valid), 64'd0);
    chk("arst.out_data", 64'(out_data), 64'd0);
    chk("arst.busy", 64'(busy), 64'd0);
    #1;
    reset = 0;
    clear_logs();
    repeat (6) tick(0, 0, 1, 0);
    chk("arst.no_xfer", 64'(xf_data.size()), 64'd0);
    chk("arst.no_issue", 64'(iss_addr.size()), 64'd0);
    exp_iss = '{1, 2, 3, 4}; exp_xf = '{3, 4, 5, 6}; exp_done = 7;
    clear_logs(); t0 = cyc;
    tick(1, 0, 1, 0);
    chk("arst.restart_addr", 64'(rd_addr), 64'h08);
    repeat (10) tick(0, 0, 1, 0);
    check_frame("arst", t0, 1'b0);

    // start held high through RUN, DRAIN and the done cycle
    clear_logs(); t0 = cyc;
    repeat (8) tick(1, 0, 1, 0);
    repeat (10) tick(0, 0, 1, 0);
    chk("hold.n_issue", 64'(iss_addr.size()), 64'd8);
    chk("hold.n_xfer", 64'(xf_data.size()), 64'd8);
    chk("hold.n_done", 64'(done_cyc.size()), 64'd2);
    for (int i = 0; i < 8; i++) begin
      if (i < iss_addr.size()) begin
        chk($sformatf("hold.addr%0d", i), 64'(iss_addr[i]), 64'(nat_addr[i % 4]));
        chk($sformatf("hold.issue_cyc%0d", i), 64'(iss_cyc[i]), 64'(t0 + (i < 4 ? i + 1 : i + 4)));
      end
      if (i < xf_data.size()) begin
        chk($sformatf("hold.data%0d", i), 64'(xf_data[i]), 64'(nat_data[i % 4]));
        chk($sformatf("hold.xfer_cyc%0d", i), 64'(xf_cyc[i]), 64'(t0 + (i < 4 ? i + 3 : i + 6)));
        chk($sformatf("hold.last%0d", i), 64'(xf_last[i]), 64'((i % 4) == 3));
      end
    end
    if (done_cyc.size() > 1) begin
      chk("hold.done0", 64'(done_cyc[0]), 64'(t0 + 7));
      chk("hold.done1", 64'(done_cyc[1]), 64'(t0 + 14));
    end

    // LANES=1, RD_LATENCY=3
    clear_logs(); t0 = cyc;
    tick(0, 0, 1, 1);
    repeat (3) tick(0, 0, 1, 0);
    chk("b.valid_t4", 64'(out_valid_b), 64'd0);
    tick(0, 0, 1, 0);
    chk("b.valid_t5", 64'(out_valid_b), 64'd1);
    chk("b.data_t5", 64'(out_data_b), 64'd0);
    repeat (10) tick(0, 0, 1, 0);
    chk("b.n_issue", 64'(b_iss.size()), 64'd8);
    chk("b.n_xfer", 64'(b_xf.size()), 64'd8);
    for (int i = 0; i < 8; i++) begin
      if (i < b_iss.size()) begin
        chk($sformatf("b.addr%0d", i), 64'(b_iss[i]), 64'(i));
        chk($sformatf("b.issue_cyc%0d", i), 64'(b_iss_cyc[i]), 64'(t0 + 1 + i));
      end
      if (i < b_xf.size()) begin
        chk($sformatf("b.data%0d", i), 64'(b_xf[i]), 64'(i));
        chk($sformatf("b.xfer_cyc%0d", i), 64'(b_xf_cyc[i]), 64'(t0 + 5 + i));
        chk($sformatf("b.last%0d", i), 64'(b_last[i]), 64'(i == 7));
      end
    end
    chk("b.n_done", 64'(b_done_cyc.size()), 64'd1);
    if (b_done_cyc.size() > 0) chk("b.done_cyc", 64'(b_done_cyc[0]), 64'(t0 + 13));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
